// File: rtl/ascon_perm_engine_pkg.sv
// Shared types, constants and helpers for the ASCON permutation engine.
package ascon_pack;

  // w0 is the most significant word, so {w0,w1,w2,w3,w4} maps directly onto the vector.
  typedef logic [0:4][63:0] type_state;

  localparam int ROUND_MAX = 12;

  localparam logic [3:0] NR_A  = 4'd12;
  localparam logic [3:0] NR_B6 = 4'd6;
  localparam logic [3:0] NR_B8 = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } perm_fsm_t;

  function automatic logic [7:0] rc(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

  function automatic logic nr_legal(input logic [3:0] nr);
    return (nr == NR_A) || (nr == NR_B6) || (nr == NR_B8);
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned sh);
    return (v >> sh) | (v << (64 - sh));
  endfunction

endpackage

// File: rtl/ascon_perm_engine_round.sv
// One combinational ASCON round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  cur_state,
  input  logic [3:0] round_idx,
  output type_state  nxt_state
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;

  always_comb begin
    a0 = cur_state[0] ^ cur_state[4];
    a1 = cur_state[1];
    a2 = cur_state[2] ^ {56'd0, rc(round_idx)} ^ cur_state[1];
    a3 = cur_state[3];
    a4 = cur_state[4] ^ cur_state[3];

    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);

    c0 = b0 ^ b4;
    c1 = b1 ^ b0;
    c2 = ~b2;
    c3 = b3 ^ b2;
    c4 = b4;

    nxt_state[0] = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
    nxt_state[1] = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
    nxt_state[2] = c2 ^ ror64(c2, 1)  ^ ror64(c2, 6);
    nxt_state[3] = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
    nxt_state[4] = c4 ^ ror64(c4, 7)  ^ ror64(c4, 41);
  end

endmodule

// File: rtl/ascon_perm_engine.sv
// Multi-cycle ASCON permutation with entry rate XOR and exit XOR, UNROLL rounds per clock.
// Define ASCON_PERM_ABORT_EN to add abort_i, which clears the state and drops back to idle mid-run.
module ascon_perm_engine
  import ascon_pack::*;
#(
  parameter int RATE_W = 64,
  parameter int DOWN_W = 256,
  parameter int UNROLL = 1
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic              start_i,
  input  logic              load_i,
  input  type_state         state_i,
  input  logic [3:0]        nrounds_i,
  input  logic              ena_xor_up_i,
  input  logic [RATE_W-1:0] rate_data_i,
  input  logic              ena_xor_down_i,
  input  logic [DOWN_W-1:0] data_xor_down_i,
`ifdef ASCON_PERM_ABORT_EN
  input  logic              abort_i,
`endif
  output logic [RATE_W-1:0] rate_o,
  output type_state         state_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  if (RATE_W != 64 && RATE_W != 128) begin : g_bad_rate
    $error("ascon_perm_engine: RATE_W must be 64 or 128");
  end
  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1 or 2");
  end
  if (DOWN_W < 1 || DOWN_W > 320) begin : g_bad_down
    $error("ascon_perm_engine: DOWN_W must be in 1..320");
  end

  perm_fsm_t         fsm_q;
  type_state         state_q;
  logic [3:0]        round_q;
  logic              down_en_q;
  logic [DOWN_W-1:0] down_data_q;

  type_state         sel_state;
  type_state         entry_state;
  type_state         chain [0:UNROLL];
  logic [319:0]      down_ext;
  type_state         final_state;
  logic              last_step;
  logic              abort_req;

`ifdef ASCON_PERM_ABORT_EN
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    sel_state   = load_i ? state_i : state_q;
    entry_state = sel_state;
    if (ena_xor_up_i) begin
      entry_state[0] = sel_state[0] ^ rate_data_i[RATE_W-1 -: 64];
      if (RATE_W == 128) entry_state[1] = sel_state[1] ^ rate_data_i[63:0];
    end
  end

  if (RATE_W == 128) begin : g_rate128
    assign rate_o = {entry_state[0], entry_state[1]};
  end else begin : g_rate64
    assign rate_o = entry_state[0];
  end

  assign chain[0] = state_q;
  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    ascon_round u_round (
      .cur_state (chain[k]),
      .round_idx (round_q + 4'(k)),
      .nxt_state (chain[k+1])
    );
  end

  // Exit XOR lands on the LSBs of {w0..w4}, i.e. w4 first.
  always_comb begin
    down_ext                = '0;
    down_ext[DOWN_W-1:0]    = down_data_q;
    final_state             = chain[UNROLL] ^ (down_en_q ? down_ext : 320'd0);
  end

  assign last_step = (round_q + 4'(UNROLL)) == 4'(ROUND_MAX);
  assign state_o   = state_q;

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      round_q     <= '0;
      down_en_q   <= 1'b0;
      down_data_q <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (fsm_q)
        ST_IDLE, ST_DONE: begin
          fsm_q <= ST_IDLE;
          if (start_i) begin
            if (nr_legal(nrounds_i)) begin
              state_q     <= entry_state;
              round_q     <= 4'(ROUND_MAX) - nrounds_i;
              down_en_q   <= ena_xor_down_i;
              down_data_q <= data_xor_down_i;
              fsm_q       <= ST_RUN;
              busy_o      <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort_req) begin
            state_q <= '0;
            fsm_q   <= ST_IDLE;
            busy_o  <= 1'b0;
          end else begin
            round_q <= round_q + 4'(UNROLL);
            if (last_step) begin
              state_q <= final_state;
              fsm_q   <= ST_DONE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              state_q <= chain[UNROLL];
            end
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

endmodule
